// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned LAT_W  = 4;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  typedef enum logic [1:0] {NONE, IF, DATA} owner_t;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating wait-cycle counter; cleared by synchronous reset.
module mem_arb_perf_cnt
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port fixed-latency memory, data over fetch.
// Optional wait-cycle counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [3:0]    dm_be,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          proto_err,
  output logic [31:0]   perf_if_wait,
  output logic [31:0]   perf_dm_wait
);

  arb_state_t       state;
  owner_t           owner;
  logic [LAT_W-1:0] cnt;
  logic             lat_we;
  logic [AW-1:0]    lat_addr;
  logic [DW-1:0]    lat_wdata;
  logic [3:0]       lat_be;
  logic             dm_any;
  logic             grant_dm;
  logic             grant_if;

  assign dm_any   = dm_read | dm_write;
  assign grant_dm = (state == IDLE) && !reset && dm_any;
  assign grant_if = (state == IDLE) && !reset && !dm_any && if_req;

  // Sequencer: the IDLE cycle that grants is the issue cycle; fields latch there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= NONE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            owner     <= grant_dm ? DATA : IF;
            lat_we    <= grant_dm && dm_write;
            lat_addr  <= grant_dm ? dm_addr : if_addr;
            lat_wdata <= grant_dm ? dm_wdata : '0;
            lat_be    <= grant_dm ? dm_be : 4'h0;
            cnt       <= LAT_W'(MEM_LAT - 1);
            state     <= (MEM_LAT == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - LAT_W'(1);
          if (cnt == LAT_W'(1)) state <= DONE;
        end
        DONE: begin
          state     <= IDLE;
          owner     <= NONE;
          cnt       <= '0;
          lat_we    <= 1'b0;
          lat_addr  <= '0;
          lat_wdata <= '0;
          lat_be    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port drive: live fields in the issue cycle, latched fields until completion.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'h0;
    proto_err = 1'b0;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    if (grant_dm) begin
      mem_en    = 1'b1;
      mem_we    = dm_write;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
      proto_err = dm_read && dm_write;
    end else if (grant_if) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if ((state != IDLE) && !reset) begin
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_be    = lat_be;
      if (state == DONE) begin
        if (owner == IF) begin
          if_ready = 1'b1;
          if_rdata = mem_rdata;
        end else if (owner == DATA) begin
          dm_ready = 1'b1;
          dm_rdata = lat_we ? '0 : mem_rdata;
        end
      end
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_any & ~dm_ready;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_cnt u_if_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_if),
    .count (perf_if_wait)
  );

  mem_arb_perf_cnt u_dm_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_mem),
    .count (perf_dm_wait)
  );
`else
  assign perf_if_wait = '0;
  assign perf_dm_wait = '0;
`endif

endmodule
